// File: rtl/ascon_pack.sv
// Shared Ascon datapath types.
// type_state holds the 320-bit permutation state as five 64-bit words.
// Word 0 is the rate word; words 1-2 receive the key before finalization.
package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

// File: rtl/xor_up_absorb_if.sv
// Plaintext-in / ciphertext-out beat bus of the absorb stage.
// slave: absorb stage (consumes data beats, produces cipher beats).
// master: producer of plaintext and consumer of ciphertext.
interface xor_up_absorb_if;
  logic [63:0] data_i;
  logic [3:0]  data_bytes_i;
  logic        data_last_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [63:0] cipher_o;
  logic [3:0]  cipher_bytes_o;
  logic        cipher_valid_o;
  logic        cipher_ready_i;

  modport slave (
    input  data_i, data_bytes_i, data_last_i, data_valid_i, cipher_ready_i,
    output data_ready_o, cipher_o, cipher_bytes_o, cipher_valid_o
  );

  modport master (
    output data_i, data_bytes_i, data_last_i, data_valid_i, cipher_ready_i,
    input  data_ready_o, cipher_o, cipher_bytes_o, cipher_valid_o
  );
endinterface

// File: rtl/xor_up_absorb.sv
// Ascon-128 upstream absorb stage: owns the 320-bit state, XORs padded 64-bit
// plaintext beats into word 0, emits cipher beats, sequences pad/key/final perms.
// Latency: beat -> cipher/state one cycle. Backpressure: a held cipher beat stalls
// data acceptance only; permutation flow continues. Optional macro: XOR_UP_DECRYPT_EN.
module xor_up_absorb
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         init_i,
`ifdef XOR_UP_DECRYPT_EN
  input  logic         decrypt_i,
`endif
  input  type_state    state_i,
  output type_state    state_o,
  input  logic [127:0] key_i,
  xor_up_absorb_if.slave bus,
  output logic         perm_start_o,
  input  logic         perm_done_i,
  output logic         done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_WAIT_PERM, S_PAD, S_FINAL, S_WAIT_FIN
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  fsm_t        ret_q, ret_d;
  type_state   state_q;
  logic        start_d;
  logic        done_d;
  logic        accept;
  logic [3:0]  n;
  logic [6:0]  mask_sh;
  logic [6:0]  pad_sh;
  logic [63:0] mask;
  logic [63:0] pad;
  logic [63:0] w0_next;
  logic [63:0] cipher_next;

`ifdef XOR_UP_DECRYPT_EN
  logic        decrypt_q;
`endif

  assign state_o = state_q;
  assign bus.data_ready_o = (fsm_q == S_ABSORB) & (~bus.cipher_valid_o | bus.cipher_ready_i);
  assign accept = bus.data_valid_i & bus.data_ready_o;

  // Byte count of the beat, padding mask and 0x80 pad byte placement.
  always_comb begin
    n = 4'd8;
    if (bus.data_last_i)
      n = (bus.data_bytes_i > 4'd8) ? 4'd8 : bus.data_bytes_i;
    // Byte 0 sits in the MSBs, so the kept bytes are the top n bytes.
    mask_sh = {(4'd8 - n), 3'b000};
    pad_sh  = {(4'd7 - n), 3'b000};
    mask    = {64{1'b1}} << mask_sh;
    pad     = (n < 4'd8) ? (64'h80 << pad_sh) : 64'h0;
    cipher_next = (state_q[0] ^ bus.data_i) & mask;
`ifdef XOR_UP_DECRYPT_EN
    if (decrypt_q)
      w0_next = ((bus.data_i & mask) | (state_q[0] & ~mask)) ^ pad;
    else
      w0_next = state_q[0] ^ ((bus.data_i & mask) | pad);
`else
    w0_next = state_q[0] ^ ((bus.data_i & mask) | pad);
`endif
  end

  // Control FSM state register and permutation return target.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q <= S_IDLE;
      ret_q <= S_ABSORB;
    end else begin
      fsm_q <= fsm_d;
      ret_q <= ret_d;
    end
  end

  // Next-state decode plus the one-cycle perm request / done strobes.
  always_comb begin
    fsm_d   = fsm_q;
    ret_d   = ret_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (init_i) fsm_d = S_ABSORB;
      end
      S_ABSORB: begin
        if (accept) begin
          if (!bus.data_last_i) begin
            fsm_d   = S_WAIT_PERM;
            ret_d   = S_ABSORB;
            start_d = 1'b1;
          end else if (n == 4'd8) begin
            // A full final block still needs the separate padding block.
            fsm_d   = S_WAIT_PERM;
            ret_d   = S_PAD;
            start_d = 1'b1;
          end else begin
            fsm_d = S_FINAL;
          end
        end
      end
      S_WAIT_PERM: begin
        if (perm_done_i) fsm_d = ret_q;
      end
      S_PAD: begin
        fsm_d = S_FINAL;
      end
      S_FINAL: begin
        start_d = 1'b1;
        fsm_d   = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (perm_done_i) begin
          done_d = 1'b1;
          fsm_d  = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State register updates: load, absorb, pad, key XOR and perm results.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= '0;
      perm_start_o <= 1'b0;
      done_o       <= 1'b0;
`ifdef XOR_UP_DECRYPT_EN
      decrypt_q    <= 1'b0;
`endif
    end else begin
      perm_start_o <= start_d;
      done_o       <= done_d;
      case (fsm_q)
        S_IDLE: begin
          if (init_i) begin
            state_q <= state_i;
`ifdef XOR_UP_DECRYPT_EN
            decrypt_q <= decrypt_i;
`endif
          end
        end
        S_ABSORB: begin
          if (accept) state_q[0] <= w0_next;
        end
        S_WAIT_PERM, S_WAIT_FIN: begin
          if (perm_done_i) state_q <= state_i;
        end
        S_PAD: begin
          state_q[0] <= state_q[0] ^ 64'h8000_0000_0000_0000;
        end
        S_FINAL: begin
          state_q[1] <= state_q[1] ^ key_i[127:64];
          state_q[2] <= state_q[2] ^ key_i[63:0];
        end
        default: ;
      endcase
    end
  end

  // Cipher output beat: a new load wins over a simultaneous drain.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bus.cipher_o       <= '0;
      bus.cipher_bytes_o <= '0;
      bus.cipher_valid_o <= 1'b0;
    end else if (accept && (n != 4'd0)) begin
      bus.cipher_o       <= cipher_next;
      bus.cipher_bytes_o <= n;
      bus.cipher_valid_o <= 1'b1;
    end else if (bus.cipher_ready_i) begin
      bus.cipher_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_up_absorb.sv
// Directed self-checking bench for xor_up_absorb.
// Inputs are driven 1 time unit after the rising edge, outputs sampled there too.
// Decrypt scenario is built only when XOR_UP_DECRYPT_EN is defined.
module tb_xor_up_absorb;
  import ascon_pack::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         init = 1'b0;
  type_state    st_in = '0;
  type_state    st_out;
  logic [127:0] key = 128'h0011223344556677_8899AABBCCDDEEFF;
  logic         perm_start;
  logic         perm_done = 1'b0;
  logic         done;
`ifdef XOR_UP_DECRYPT_EN
  logic         decrypt = 1'b0;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  xor_up_absorb_if bus ();

  xor_up_absorb dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .init_i       (init),
`ifdef XOR_UP_DECRYPT_EN
    .decrypt_i    (decrypt),
`endif
    .state_i      (st_in),
    .state_o      (st_out),
    .key_i        (key),
    .bus          (bus),
    .perm_start_o (perm_start),
    .perm_done_i  (perm_done),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    init = 1'b0;
    perm_done = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_last_i = 1'b0;
    bus.data_bytes_i = 4'd0;
    bus.data_i = '0;
    bus.cipher_ready_i = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_op(input type_state s);
    st_in = s;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset;
    bus.data_valid_i = 1'b0;
    bus.cipher_ready_i = 1'b1;
    rst = 1'b1;
    tick();
    total_cnt++; if (st_out !== '0) $display("FAIL reset_state: got %h want 0", st_out); else pass_cnt++;
    total_cnt++; if ({bus.cipher_valid_o, perm_start, done, bus.data_ready_o} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {bus.cipher_valid_o, perm_start, done, bus.data_ready_o}); else pass_cnt++;
    total_cnt++; if ({bus.cipher_o, bus.cipher_bytes_o} !== 68'h0) $display("FAIL reset_cipher: got %h want 0", {bus.cipher_o, bus.cipher_bytes_o}); else pass_cnt++;
    rst = 1'b0;
    bus.data_valid_i = 1'b1;
    bus.data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    // IDLE must ignore data beats.
    total_cnt++; if ({bus.data_ready_o, bus.cipher_valid_o} !== 2'b00) $display("FAIL idle_ignores_data: got %b want 00", {bus.data_ready_o, bus.cipher_valid_o}); else pass_cnt++;
    bus.data_valid_i = 1'b0;
  endtask

  task automatic test_full_block;
    type_state s1;
    type_state s2;
    do_reset();
    start_op('0);
    total_cnt++; if (bus.data_ready_o !== 1'b1) $display("FAIL full_ready: got %b want 1", bus.data_ready_o); else pass_cnt++;
    bus.data_i = 64'h0123456789ABCDEF; bus.data_bytes_i = 4'd8; bus.data_last_i = 1'b1; bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    total_cnt++; if (bus.cipher_o !== 64'h0123456789ABCDEF || bus.cipher_bytes_o !== 4'd8 || bus.cipher_valid_o !== 1'b1) $display("FAIL full_cipher: got %h/%0d/%b want 0123456789abcdef/8/1", bus.cipher_o, bus.cipher_bytes_o, bus.cipher_valid_o); else pass_cnt++;
    total_cnt++; if (st_out[0] !== 64'h0123456789ABCDEF) $display("FAIL full_w0: got %h want 0123456789abcdef", st_out[0]); else pass_cnt++;
    total_cnt++; if (perm_start !== 1'b1) $display("FAIL full_perm_start: got %b want 1", perm_start); else pass_cnt++;
    tick();
    total_cnt++; if ({perm_start, bus.cipher_valid_o} !== 2'b00) $display("FAIL full_start_pulse: got %b want 00", {perm_start, bus.cipher_valid_o}); else pass_cnt++;
    s1[0] = 64'h1111111111111111; s1[1] = 64'h2222222222222222; s1[2] = 64'h3333333333333333;
    s1[3] = 64'h4444444444444444; s1[4] = 64'h5555555555555555;
    st_in = s1; perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    total_cnt++; if (st_out !== s1) $display("FAIL full_perm_load: got %h want %h", st_out, s1); else pass_cnt++;
    tick();
    total_cnt++; if (st_out[0] !== 64'h9111111111111111) $display("FAIL full_pad: got %h want 9111111111111111", st_out[0]); else pass_cnt++;
    tick();
    total_cnt++; if (st_out[1] !== 64'h2233001166774455 || st_out[2] !== 64'hBBAA9988FFEEDDCC) $display("FAIL full_key_xor: got %h %h want 2233001166774455 bbaa9988ffeeddcc", st_out[1], st_out[2]); else pass_cnt++;
    total_cnt++; if (perm_start !== 1'b1) $display("FAIL full_final_start: got %b want 1", perm_start); else pass_cnt++;
    s2 = '0; s2[3] = 64'hCAFEF00DCAFEF00D;
    st_in = s2; perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    total_cnt++; if (done !== 1'b1 || st_out !== s2) $display("FAIL full_done: got %b/%h want 1/%h", done, st_out, s2); else pass_cnt++;
    tick();
    total_cnt++; if ({done, bus.data_ready_o} !== 2'b00) $display("FAIL full_idle: got %b want 00", {done, bus.data_ready_o}); else pass_cnt++;
  endtask

  task automatic test_partial;
    type_state junk;
    do_reset();
    start_op('0);
    // A stray perm_done while absorbing must not touch the state.
    junk = '0; junk[0] = 64'hDEADDEADDEADDEAD;
    st_in = junk; perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    total_cnt++; if (st_out !== '0) $display("FAIL partial_stray_done: got %h want 0", st_out); else pass_cnt++;
    bus.data_i = 64'hAABBCC0000000000; bus.data_bytes_i = 4'd3; bus.data_last_i = 1'b1; bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    total_cnt++; if (st_out[0] !== 64'hAABBCC8000000000) $display("FAIL partial_w0: got %h want aabbcc8000000000", st_out[0]); else pass_cnt++;
    total_cnt++; if (bus.cipher_o !== 64'hAABBCC0000000000 || bus.cipher_bytes_o !== 4'd3) $display("FAIL partial_cipher: got %h/%0d want aabbcc0000000000/3", bus.cipher_o, bus.cipher_bytes_o); else pass_cnt++;
    total_cnt++; if (perm_start !== 1'b0) $display("FAIL partial_no_perm: got %b want 0", perm_start); else pass_cnt++;
    tick();
    // No PAD: straight into FINAL, key XOR lands and finalization perm starts.
    total_cnt++; if (perm_start !== 1'b1 || st_out[1] !== 64'h0011223344556677 || st_out[0] !== 64'hAABBCC8000000000) $display("FAIL partial_final: got %b/%h/%h want 1/0011223344556677/aabbcc8000000000", perm_start, st_out[1], st_out[0]); else pass_cnt++;
    st_in = junk; perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    total_cnt++; if (done !== 1'b1) $display("FAIL partial_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_zero_bytes;
    do_reset();
    start_op('0);
    bus.data_i = 64'hDEADBEEFDEADBEEF; bus.data_bytes_i = 4'd0; bus.data_last_i = 1'b1; bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    total_cnt++; if (bus.cipher_valid_o !== 1'b0) $display("FAIL zero_no_cipher: got %b want 0", bus.cipher_valid_o); else pass_cnt++;
    total_cnt++; if (st_out[0] !== 64'h8000000000000000) $display("FAIL zero_pad: got %h want 8000000000000000", st_out[0]); else pass_cnt++;
    tick();
    total_cnt++; if (perm_start !== 1'b1) $display("FAIL zero_final_start: got %b want 1", perm_start); else pass_cnt++;
    perm_done = 1'b1; st_in = '0;
    tick();
    perm_done = 1'b0;
    total_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_back_to_back_stall;
    type_state s0;
    type_state s3;
    do_reset();
    s0 = '0; s0[0] = 64'hFFFF0000FFFF0000;
    start_op(s0);
    bus.cipher_ready_i = 1'b0;
    bus.data_i = 64'h1234567890ABCDEF; bus.data_bytes_i = 4'd8; bus.data_last_i = 1'b0; bus.data_valid_i = 1'b1;
    tick();
    // Second beat is offered immediately and stays offered through the stall.
    bus.data_i = 64'hA5A5FFFFFFFFFFFF; bus.data_bytes_i = 4'd2; bus.data_last_i = 1'b1;
    total_cnt++; if (bus.cipher_o !== 64'hEDCB56786F54CDEF || perm_start !== 1'b1) $display("FAIL stall_first: got %h/%b want edcb56786f54cdef/1", bus.cipher_o, perm_start); else pass_cnt++;
    s3 = '0; s3[0] = 64'h0102030405060708; s3[4] = 64'h7777777777777777;
    for (int i = 0; i < 5; i++) begin
      perm_done = (i == 1);
      st_in = s3;
      tick();
      total_cnt++; if (bus.cipher_o !== 64'hEDCB56786F54CDEF || bus.cipher_valid_o !== 1'b1 || bus.data_ready_o !== 1'b0) $display("FAIL stall_hold_%0d: got %h/%b/%b want edcb56786f54cdef/1/0", i, bus.cipher_o, bus.cipher_valid_o, bus.data_ready_o); else pass_cnt++;
    end
    perm_done = 1'b0;
    total_cnt++; if (st_out !== s3) $display("FAIL stall_perm_advanced: got %h want %h", st_out, s3); else pass_cnt++;
    bus.cipher_ready_i = 1'b1;
    #1;
    total_cnt++; if (bus.data_ready_o !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", bus.data_ready_o); else pass_cnt++;
    tick();
    bus.data_valid_i = 1'b0;
    total_cnt++; if (bus.cipher_valid_o !== 1'b1 || bus.cipher_o !== 64'hA4A7000000000000 || bus.cipher_bytes_o !== 4'd2) $display("FAIL b2b_new_wins: got %b/%h/%0d want 1/a4a7000000000000/2", bus.cipher_valid_o, bus.cipher_o, bus.cipher_bytes_o); else pass_cnt++;
    total_cnt++; if (st_out[0] !== 64'hA4A7830405060708) $display("FAIL b2b_w0: got %h want a4a7830405060708", st_out[0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_perm;
    type_state s;
    do_reset();
    s = '0; s[0] = 64'h00000000000000FF;
    start_op(s);
    bus.data_i = 64'h1111111111111111; bus.data_bytes_i = 4'd8; bus.data_last_i = 1'b0; bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++; if (st_out !== '0 || bus.cipher_valid_o !== 1'b0 || bus.cipher_o !== 64'h0) $display("FAIL midrst_async_clear: got %h/%b/%h want 0/0/0", st_out, bus.cipher_valid_o, bus.cipher_o); else pass_cnt++;
    tick();
    rst = 1'b0;
    s[1] = 64'h5A5A5A5A5A5A5A5A;
    st_in = s; perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    total_cnt++; if (st_out !== '0 || done !== 1'b0 || bus.data_ready_o !== 1'b0 || perm_start !== 1'b0) $display("FAIL midrst_done_ignored: got %h/%b/%b/%b want 0/0/0/0", st_out, done, bus.data_ready_o, perm_start); else pass_cnt++;
  endtask

`ifdef XOR_UP_DECRYPT_EN
  task automatic test_decrypt;
    type_state s;
    do_reset();
    s = '0; s[0] = 64'hFFFFFFFFFFFFFFFF;
    decrypt = 1'b1;
    start_op(s);
    decrypt = 1'b0;
    bus.data_i = 64'h00FFFFFFFFFFFFFF; bus.data_bytes_i = 4'd8; bus.data_last_i = 1'b0; bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    total_cnt++; if (bus.cipher_o !== 64'hFF00000000000000) $display("FAIL dec_plain: got %h want ff00000000000000", bus.cipher_o); else pass_cnt++;
    total_cnt++; if (st_out[0] !== 64'h00FFFFFFFFFFFFFF) $display("FAIL dec_w0: got %h want 00ffffffffffffff", st_out[0]); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.data_i = '0;
    bus.data_bytes_i = '0;
    bus.data_last_i = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.cipher_ready_i = 1'b1;
    test_reset();
    test_full_block();
    test_partial();
    test_zero_bytes();
    test_back_to_back_stall();
    test_reset_mid_perm();
`ifdef XOR_UP_DECRYPT_EN
    test_decrypt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
